// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port (i_*) and a data port (d_*). Requests are granted one at a time in
// round-robin order. The winner's request is copied into the registered m_*
// outputs, and m_en pulses for one cycle. The arbiter then waits MEM_LAT cycles,
// captures m_rdata and returns it with a 1-cycle ack.
// Ports:
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_rdata/i_ack                    fetch side
//   d_req/d_addr/d_wdata/d_wen/d_rd -> d_rdata/d_ack data side
//   m_en/m_addr/m_wdata/m_wen/m_rd, m_rdata          memory side
//   grant                                            debug owner (01 fetch, 10 data)
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic                d_rd,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_en,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wen,
  output logic                m_rd,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          grant
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win_data_q, win_data_d;
  logic                last_data_q, last_data_d;
  logic                m_en_q, m_en_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]     m_wen_q, m_wen_d;
  logic                m_rd_q, m_rd_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [1:0]          grant_q, grant_d;
  logic                pick_data;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      m_en_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wen_q     <= '0;
      m_rd_q      <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_data_q  <= win_data_d;
      last_data_q <= last_data_d;
      m_en_q      <= m_en_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wen_q     <= m_wen_d;
      m_rd_q      <= m_rd_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      grant_q     <= grant_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_data_d  = win_data_q;
    last_data_d = last_data_q;
    m_en_d      = 1'b0;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wen_d     = m_wen_q;
    m_rd_d      = m_rd_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    grant_d     = grant_q;
    // On a tie the side that did not win last time gets the port
    pick_data   = d_req & (~i_req | ~last_data_q);

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          win_data_d = pick_data;
          m_en_d     = 1'b1;
          state_d    = S_ISSUE;
          if (pick_data) begin
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            grant_d   = 2'b10;
            // Any nonzero byte enable is a store; otherwise a load, even if d_rd=0
            if (d_wen != '0) begin
              m_wen_d = d_wen;
              m_rd_d  = 1'b0;
            end else begin
              m_wen_d = '0;
              m_rd_d  = 1'b1;
            end
          end else begin
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wen_d   = '0;
            m_rd_d    = 1'b1;
            grant_d   = 2'b01;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // m_rdata is valid during this cycle; capture and raise the ack
          if (win_data_q) begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end
          m_wen_d = '0;
          m_rd_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        last_data_d = win_data_q;
        grant_d     = 2'b00;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_ack   = d_ack_q;
  assign m_en    = m_en_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wen   = m_wen_q;
  assign m_rd    = m_rd_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances are used: u1 has MEM_LAT=1 and
// u3 has MEM_LAT=3. Each instance has its own memory model. The memory model
// returns addr^3 at the valid cycle (0xCAFEF00D for address 0x200) and
// garbage at every other cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        i_req, d_req, d_rd;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wen;
  logic [31:0] cyc;

  logic        a_i_ack, a_d_ack, a_m_en, a_m_rd;
  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
  logic [3:0]  a_m_wen;
  logic [1:0]  a_grant;
  logic        b_i_ack, b_d_ack, b_m_en, b_m_rd;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
  logic [3:0]  b_m_wen;
  logic [1:0]  b_grant;
  logic [2:0]  a_enp, b_enp;

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) u1 (
    .clk(clk), .reset(rst_n),
    .i_req(i_req & ~sel), .i_addr(i_addr), .i_rdata(a_i_rdata), .i_ack(a_i_ack),
    .d_req(d_req & ~sel), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
    .d_rd(d_rd), .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .m_en(a_m_en), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_wen(a_m_wen),
    .m_rd(a_m_rd), .m_rdata(a_m_rdata), .grant(a_grant));

  mem_port_arbiter #(.MEM_LAT(3), .ADDR_W(32), .DATA_W(32)) u3 (
    .clk(clk), .reset(rst_n),
    .i_req(i_req & sel), .i_addr(i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_req(d_req & sel), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
    .d_rd(d_rd), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .m_en(b_m_en), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wen(b_m_wen),
    .m_rd(b_m_rd), .m_rdata(b_m_rdata), .grant(b_grant));

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h200) ? 32'hCAFEF00D : (a ^ 32'h3);
  endfunction

  // Memory model: data is valid exactly MEM_LAT cycles after m_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_enp <= '0;
      b_enp <= '0;
    end else begin
      a_enp <= {a_enp[1:0], a_m_en};
      b_enp <= {b_enp[1:0], b_m_en};
    end
  end
  always_ff @(posedge clk) cyc <= cyc + 32'd1;
  assign a_m_rdata = a_enp[0] ? mem_f(a_m_addr) : (32'hBAD0_0000 ^ cyc);
  assign b_m_rdata = b_enp[2] ? mem_f(b_m_addr) : (32'hBAD0_0000 ^ cyc);

  // Outputs of the instance selected by sel
  logic        o_i_ack, o_d_ack, o_m_en, o_m_rd;
  logic [31:0] o_i_rdata, o_d_rdata, o_m_addr, o_m_wdata;
  logic [3:0]  o_m_wen;
  logic [1:0]  o_grant;
  assign o_i_ack   = sel ? b_i_ack   : a_i_ack;
  assign o_d_ack   = sel ? b_d_ack   : a_d_ack;
  assign o_m_en    = sel ? b_m_en    : a_m_en;
  assign o_m_rd    = sel ? b_m_rd    : a_m_rd;
  assign o_i_rdata = sel ? b_i_rdata : a_i_rdata;
  assign o_d_rdata = sel ? b_d_rdata : a_d_rdata;
  assign o_m_addr  = sel ? b_m_addr  : a_m_addr;
  assign o_m_wdata = sel ? b_m_wdata : a_m_wdata;
  assign o_m_wen   = sel ? b_m_wen   : a_m_wen;
  assign o_grant   = sel ? b_grant   : a_grant;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        rd;
    logic        exp_rd;
    logic [3:0]  exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strobes"}, 64'({o_i_ack, o_d_ack, o_m_en, o_m_rd}), 64'(0));
    chk({tag, "_grant"},   64'(o_grant),   64'(0));
    chk({tag, "_m_addr"},  64'(o_m_addr),  64'(0));
    chk({tag, "_m_wdata"}, 64'(o_m_wdata), 64'(0));
    chk({tag, "_m_wen"},   64'(o_m_wen),   64'(0));
    chk({tag, "_rdata"},   {o_i_rdata, o_d_rdata}, 64'(0));
  endtask

  // Single transaction from an idle arbiter; called at a negedge
  task automatic run_txn(input string tag, input vec_t v, input int lat);
    int  n;
    bit  seen;
    i_req = ~v.is_d; d_req = v.is_d;
    i_addr = v.addr; d_addr = v.addr; d_wdata = v.wdata; d_wen = v.wen; d_rd = v.rd;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (o_m_en) seen = 1;
    end
    chk({tag, "_en_lat"}, 64'(n), 64'(1));
    chk({tag, "_m_addr"}, 64'(o_m_addr), 64'(v.addr));
    chk({tag, "_m_rd"},   64'(o_m_rd), 64'(v.exp_rd));
    chk({tag, "_m_wen"},  64'(o_m_wen), 64'(v.exp_wen));
    chk({tag, "_grant"},  64'(o_grant), v.is_d ? 64'(2) : 64'(1));
    if (v.wen != 4'h0) chk({tag, "_m_wdata"}, 64'(o_m_wdata), 64'(v.wdata));
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (o_i_ack || o_d_ack) seen = 1;
    end
    chk({tag, "_ack_lat"},  64'(n), 64'(lat + 2));
    chk({tag, "_ack_side"}, 64'({o_d_ack, o_i_ack}), v.is_d ? 64'(2) : 64'(1));
    chk({tag, "_done_strb"}, 64'({o_m_en, o_m_rd, o_m_wen}), 64'(0));
    if (v.wen == 4'h0)
      chk({tag, "_rdata"}, 64'(v.is_d ? o_d_rdata : o_i_rdata), 64'(v.exp_rdata));
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, 64'({o_d_ack, o_i_ack, o_grant}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   n;
    bit   seen;

    vecs[0] = '{1'b0, 32'h10,   32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 32'h13};
    vecs[1] = '{1'b1, 32'h100,  32'hDEADBEEF, 4'b0011, 1'b0, 1'b0, 4'b0011, 32'h0};
    vecs[2] = '{1'b1, 32'h44,   32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 32'h47};
    vecs[3] = '{1'b1, 32'h80,   32'h0,        4'b0000, 1'b0, 1'b1, 4'b0000, 32'h83};
    vecs[4] = '{1'b1, 32'h104,  32'h12345678, 4'b1111, 1'b1, 1'b0, 4'b1111, 32'h0};
    vecs[5] = '{1'b0, 32'h2000, 32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 32'h2003};

    cyc = 32'h0;
    rst_n = 1'b0; sel = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h0; d_wen = 4'h0; d_rd = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("rst_a");
    sel = 1'b1; #1;
    check_zero("rst_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both requests held from reset release: grants alternate F,D,F,D
    for (int k = 0; k < 4; k++) begin
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(negedge clk); n++;
        if (o_m_en) seen = 1;
      end
      chk("tie_en_lat", 64'(n), 64'(1));
      chk("tie_grant", 64'(o_grant), (k % 2 == 1) ? 64'(2) : 64'(1));
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(negedge clk); n++;
        if (o_i_ack || o_d_ack) seen = 1;
      end
      chk("tie_ack_lat", 64'(n), 64'(2));
      chk("tie_ack_side", 64'({o_d_ack, o_i_ack}), (k % 2 == 1) ? 64'(2) : 64'(1));
      chk("tie_rdata", (k % 2 == 1) ? 64'(o_d_rdata) : 64'(o_i_rdata),
          (k % 2 == 1) ? 64'(32'h23) : 64'(32'h13));
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      chk("tie_ack_pulse", 64'({o_d_ack, o_i_ack}), 64'(0));
    end

    // Single-request vectors on MEM_LAT=1
    for (int i = 0; i < 6; i++) run_txn($sformatf("v%0d", i), vecs[i], 1);

    // MEM_LAT=3: store, then load of 0x200 with d_addr changed after issue
    sel = 1'b1;
    run_txn("l3_st", vecs[1], 3);
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h200; d_rd = 1'b1; d_wen = 4'h0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (o_m_en) seen = 1;
    end
    chk("l3_en_lat", 64'(n), 64'(1));
    chk("l3_m_addr", 64'(o_m_addr), 64'(32'h200));
    d_addr = 32'h999; d_wdata = 32'h5555;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      chk("l3_addr_hold", 64'(o_m_addr), 64'(32'h200));
      if (o_d_ack) seen = 1;
    end
    chk("l3_ack_lat", 64'(n), 64'(5));
    chk("l3_rdata", 64'(o_d_rdata), 64'(32'hCAFEF00D));
    chk("l3_i_ack", 64'(o_i_ack), 64'(0));
    d_req = 1'b0;
    @(negedge clk);
    chk("l3_ack_drop", 64'({o_d_ack, o_i_ack}), 64'(0));

    // Reset while waiting for memory data
    i_req = 1'b1; i_addr = 32'h30;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (o_m_en) seen = 1;
    end
    chk("rw_en_lat", 64'(n), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rw");
    i_addr = 32'h40;
    repeat (2) begin
      @(negedge clk);
      chk("rw_no_ack", 64'({o_d_ack, o_i_ack, o_m_en}), 64'(0));
    end
    rst_n = 1'b1;
    v = '{1'b0, 32'h40, 32'h0, 4'b0000, 1'b1, 1'b1, 4'b0000, 32'h43};
    run_txn("rw_after", v, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
